// File: rtl/pipe_sched_pkg.sv
// pipe_sched_pkg: shared defaults, tag type and golden arithmetic for pipe_sched.
// Contents: DEF_N / DEF_NREQ / DEF_LAT defaults, tag_t {valid, idx}, ref_f().
// ref_f is the reference for the external pipeline: ((a+b)+(c-d))*d mod 2^N.
package pipe_sched_pkg;

  localparam int DEF_N    = 10;
  localparam int DEF_NREQ = 4;
  localparam int DEF_LAT  = 3;
  localparam int TAG_IW   = $clog2(DEF_NREQ);

  // One slot of the tag pipe: which requester owns the result in that slot.
  typedef struct packed {
    logic              valid;
    logic [TAG_IW-1:0] idx;
  } tag_t;

  function automatic logic [DEF_N-1:0] ref_f(input logic [DEF_N-1:0] a,
                                             input logic [DEF_N-1:0] b,
                                             input logic [DEF_N-1:0] c,
                                             input logic [DEF_N-1:0] d);
    logic [DEF_N-1:0] s;
    s = (a + b) + (c - d);
    return s * d;
  endfunction

endpackage

// File: rtl/pipe_sched_rr_arb.sv
// rr_arb: NREQ-wide round-robin arbiter; search starts at ptr and wraps.
// Ports: clk, rst_n (sync, active-low), req, en in; one-hot gnt, gnt_idx out.
// gnt is combinational; ptr advances past the winner on every grant, else holds.
module rr_arb
  import pipe_sched_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  // A grant always completes a transfer (grant implies request), so the
  // pointer moves exactly on handshakes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_sched.sv
// pipe_sched: shares one fixed-latency pipeline (LAT regs) among NREQ requesters.
// Ports: req_valid/req_ready + req_a..d in; pipe_a..d out, pipe_f in;
//        rsp_valid (one-hot pulse) / rsp_data out; inflight, busy status.
module pipe_sched
  import pipe_sched_pkg::*;
#(
  parameter  int N    = DEF_N,
  parameter  int NREQ = DEF_NREQ,
  parameter  int LAT  = DEF_LAT,
  localparam int IW   = $clog2(NREQ),
  localparam int CW   = $clog2(LAT + 2)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_en,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*N-1:0] req_c,
  input  logic [NREQ*N-1:0] req_d,
  output logic [N-1:0]    pipe_a,
  output logic [N-1:0]    pipe_b,
  output logic [N-1:0]    pipe_c,
  output logic [N-1:0]    pipe_d,
  input  logic [N-1:0]    pipe_f,
  output logic [NREQ-1:0] rsp_valid,
  output logic [N-1:0]    rsp_data,
  output logic [CW-1:0]   inflight,
  output logic            busy
);

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            xfer;
  tag_t            tags [LAT+1];
  tag_t            tail;

  // Gating en with rst_n keeps req_ready low while reset is asserted.
  rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (issue_en & rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |(gnt & req_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_a <= '0;
      pipe_b <= '0;
      pipe_c <= '0;
      pipe_d <= '0;
    end else if (xfer) begin
      pipe_a <= req_a[gnt_idx*N +: N];
      pipe_b <= req_b[gnt_idx*N +: N];
      pipe_c <= req_c[gnt_idx*N +: N];
      pipe_d <= req_d[gnt_idx*N +: N];
    end
  end

  // LAT+1 tag slots: one for the issue register plus one per pipeline stage,
  // so the tail lines up with the cycle pipe_f carries that result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= LAT; k++) tags[k] <= '0;
    end else begin
      tags[0] <= '{valid: xfer, idx: gnt_idx};
      for (int k = 1; k <= LAT; k++) tags[k] <= tags[k-1];
    end
  end

  assign tail      = tags[LAT];
  assign rsp_valid = (tail.valid && rst_n) ? (NREQ'(1) << tail.idx) : '0;
  assign rsp_data  = pipe_f;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({xfer, tail.valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = rst_n && (inflight != '0);

endmodule

// File: tb/tb_pipe_sched.sv
module tb_pipe_sched;
  import pipe_sched_pkg::*;

  localparam int N    = DEF_N;
  localparam int NREQ = DEF_NREQ;
  localparam int LAT  = DEF_LAT;
  localparam int CW   = $clog2(LAT + 2);
  localparam int MOD  = 1 << N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              issue_en = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
  logic [N-1:0]      pipe_a, pipe_b, pipe_c, pipe_d, pipe_f;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_data;
  logic [CW-1:0]     inflight;
  logic              busy;

  pipe_sched dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_d(pipe_d),
    .pipe_f(pipe_f), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  // External pipeline: LAT registers, no reset, no stall.
  logic [N-1:0] stg [LAT];
  always @(posedge clk) begin
    stg[0] <= ref_f(pipe_a, pipe_b, pipe_c, pipe_d);
    for (int k = 1; k < LAT; k++) stg[k] <= stg[k-1];
  end
  assign pipe_f = stg[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic in plain integers.
  function automatic int model_f(int a, int b, int c, int d);
    int s;
    s = a + b + c - d;
    s = ((s % MOD) + MOD) % MOD;
    return (s * d) % MOD;
  endfunction

  // Requester front-end state.
  logic [NREQ-1:0] v = '0;
  int ra [NREQ], rb [NREQ], rc [NREQ], rd [NREQ];

  task automatic drive();
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = N'(ra[i]);
      req_b[i*N +: N] = N'(rb[i]);
      req_c[i*N +: N] = N'(rc[i]);
      req_d[i*N +: N] = N'(rd[i]);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b, input int c, input int d);
    v[i] = 1'b1; ra[i] = a; rb[i] = b; rc[i] = c; rd[i] = d;
    drive();
  endtask

  // One clock: retire granted requests, optionally raise new ones in mask.
  task automatic tick(input int pnew, input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) v[i] = 1'b0;
      if (!v[i] && mask[i] && int'($urandom_range(99)) < pnew) begin
        v[i]  = 1'b1;
        ra[i] = int'($urandom_range(MOD - 1));
        rb[i] = int'($urandom_range(MOD - 1));
        rc[i] = int'($urandom_range(MOD - 1));
        rd[i] = int'($urandom_range(MOD - 1));
      end
    end
    drive();
  endtask

  // Scoreboard.
  typedef struct { int idx; int f; int cyc; } exp_t;
  exp_t q[$];
  int   mptr = 0;
  bit   hist [LAT+1];
  bit   was_rst = 1'b1;
  int   ck_g, ck_j, ck_sum;
  logic [NREQ-1:0] exp_rdy;

  // Stimulus-side checker: expected grant, inflight/busy, pushes expectations.
  always @(negedge clk) begin
    ck_g = -1;
    if (rst_n && issue_en) begin
      for (int k = 0; k < NREQ; k++) begin
        ck_j = (mptr + k) % NREQ;
        if (ck_g < 0 && req_valid[ck_j]) ck_g = ck_j;
      end
    end
    exp_rdy = '0;
    if (ck_g >= 0) exp_rdy[ck_g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (!rst_n) begin
      chk("busy_in_reset", busy, 0);
      mptr = 0;
      q.delete();
      for (int k = 0; k <= LAT; k++) hist[k] = 1'b0;
      was_rst = 1'b1;
    end else begin
      if (was_rst) chk("pipe_after_reset", {pipe_a, pipe_b, pipe_c, pipe_d}, 0);
      was_rst = 1'b0;
      ck_sum = 0;
      for (int k = 0; k <= LAT; k++) ck_sum += int'(hist[k]);
      chk("inflight", inflight, ck_sum);
      chk("busy", busy, ck_sum != 0);
      for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = (ck_g >= 0);
      if (ck_g >= 0) begin
        q.push_back('{idx: ck_g, f: model_f(ra[ck_g], rb[ck_g], rc[ck_g], rd[ck_g]), cyc: cyc});
        mptr = (ck_g + 1) % NREQ;
      end
    end
  end

  // Response monitor.
  exp_t e;
  logic [NREQ-1:0] exp_rv;
  always @(negedge clk) begin
    while (rst_n && q.size() > 0 && q[0].cyc + LAT + 1 < cyc) begin
      e = q.pop_front();
      chk("rsp_missed", 0, 1);
    end
    if (!rst_n) begin
      chk("rsp_in_reset", rsp_valid, 0);
    end else if (q.size() > 0 && q[0].cyc + LAT + 1 == cyc) begin
      e = q.pop_front();
      exp_rv = '0;
      exp_rv[e.idx] = 1'b1;
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_data", rsp_data, e.f);
    end else begin
      chk("rsp_idle", rsp_valid, 0);
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while (v != '0 && k < 200) begin
      tick(0, '0);
      k++;
    end
    if (v != '0) chk("drain_timeout", v, 0);
    repeat (LAT + 3) tick(0, '0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = 0; rb[i] = 0; rc[i] = 0; rd[i] = 0;
    end
    rst_n = 1'b0; issue_en = 1'b1; v = '0; drive();
    repeat (3) tick(0, '0);
    rst_n = 1'b1;
    repeat (2) tick(0, '0);

    // Single request and wrap-around arithmetic cases.
    set_req(0, 3, 4, 10, 2);
    drain();
    set_req(1, 1023, 1, 5, 3);
    set_req(2, 600, 0, 2, 2);
    set_req(3, 1, 1, 0, 1);
    drain();

    // All requesters continuously valid.
    for (int i = 0; i < NREQ; i++)
      set_req(i, int'($urandom_range(MOD-1)), int'($urandom_range(MOD-1)),
              int'($urandom_range(MOD-1)), int'($urandom_range(MOD-1)));
    repeat (30) tick(100, '1);
    drain();

    // Fairness: 1 and 3 alternate, then 0 joins.
    repeat (10) tick(100, 4'b1010);
    repeat (10) tick(100, 4'b1011);
    drain();

    // issue_en low for 3 cycles with work pending.
    repeat (6) tick(100, '1);
    issue_en = 1'b0;
    repeat (3) tick(100, '1);
    issue_en = 1'b1;
    repeat (6) tick(100, '1);

    // Reset mid-operation with results in flight.
    rst_n = 1'b0;
    tick(0, '0);
    rst_n = 1'b1;
    repeat (8) tick(100, '1);
    drain();

    // Randomized mix.
    for (int n = 0; n < 500; n++) begin
      issue_en = ($urandom_range(99) < 85);
      rst_n    = ($urandom_range(199) != 0);
      tick(int'($urandom_range(100)), NREQ'($urandom_range((1 << NREQ) - 1)));
    end
    issue_en = 1'b1;
    rst_n = 1'b1;
    drain();

    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_sched.md
# pipe_sched

Scheduler that shares one fixed-latency arithmetic pipeline, F = ((A+B)+(C−D))·D mod 2^N, among NREQ requesters. It arbitrates round-robin, registers the winning operand set into the pipeline inputs and carries a requester tag alongside the data. When the result emerges it returns the result to the owning requester. It sits between the requester front-ends and the pipeline instance; the pipeline itself has no reset, no stall and no valid signalling.

## Interface
- N, 10, operand/result width
- NREQ, 4, number of requesters (≥2)
- LAT, 3, pipeline register depth, pipe_f input to output
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- issue_en  in  1  when low, no new grants; in-flight work still drains
- req_valid  in  NREQ  per-requester operand set valid
- req_ready  out  NREQ  one-hot grant, combinational from req_valid, issue_en, rr pointer
- req_a, req_b, req_c, req_d  in  NREQ·N each  packed operands, requester i at bits [i·N +: N]
- pipe_a, pipe_b, pipe_c, pipe_d  out  N each  registered operands to the pipeline
- pipe_f  in  N  pipeline result
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse per result
- rsp_data  out  N  equals pipe_f, meaningful only while rsp_valid ≠ 0
- inflight  out  $clog2(LAT+2)  issued results not yet returned
- busy  out  1  inflight ≠ 0

## Operation
- Arbitration: round-robin pointer ptr (0..NREQ−1). Grant goes to the first i with req_valid[i], searching ptr, ptr+1, … with wrap. Grant only while issue_en=1 and rst_n=1. At most one req_ready bit is high.
- Handshake: a transfer happens when req_valid[i] & req_ready[i]. On that edge, ptr becomes (i+1) mod NREQ. With no transfer, ptr holds.
- Issue register: on a transfer, pipe_a..d load requester i's operands. Otherwise pipe_a..d hold their value and the slot carries no tag.
- Tag pipe: LAT+1 entries of {valid, idx[$clog2(NREQ)-1:0]}, shifting every cycle. Entry 0 takes {transfer, i}.
- Response: the tail entry drives rsp_valid = valid ? onehot(idx) : 0. rsp_data = pipe_f.
- inflight: +1 on a transfer, −1 on a response, unchanged when both occur in the same cycle. It never exceeds LAT+1.
- Requesters must accept responses unconditionally. There is no response backpressure.
- Reset (rst_n=0 at an edge), including mid-operation:
  - ptr=0; all tag entries invalid; inflight=0; pipe_a..d=0.
  - Outputs during and after reset: req_ready=0, rsp_valid=0, busy=0.
  - Results already in the pipeline are discarded.

## Timing
- Throughput: one transfer per cycle, sustained, with no bubbles.
- Latency: a handshake in cycle c produces:
  - pipe_a..d valid in c+1;
  - pipeline samples in c+1..c+LAT;
  - rsp_valid high in cycle c+LAT+1, which is 4 cycles with default LAT.
- Results return strictly in issue order.
- issue_en falling: no transfer in that cycle. Earlier transfers still respond on schedule.
- Simultaneous requests: exactly one grant per cycle. The others keep req_valid high; they must hold their operands stable until granted.

## Structure
- Package pipe_sched_pkg:
  - default N, NREQ, LAT;
  - tag struct typedef {valid, idx};
  - golden function ref_f(a,b,c,d) returning ((a+b)+(c−d))·d truncated to N bits.
- Sub-module rr_arb: NREQ-wide round-robin arbiter holding ptr, with inputs req, en and outputs one-hot gnt and gnt_idx.
- The pipeline is instantiated beside pipe_sched at the top level, not inside it.

## Test plan
- Single request: requester 0 sends A=3, B=4, C=10, D=2 in cycle c → rsp_valid=4'b0001, rsp_data=30 in cycle c+4. busy is high for cycles c+1..c+4 and low afterwards.
- Wrap arithmetic:
  - A=1023, B=1, C=5, D=3 → 6;
  - A=600, B=0, C=2, D=2 → 176;
  - A=1, B=1, C=0, D=1 → 1.
- All four requesters valid continuously from reset release → grants 0,1,2,3,0,… one per cycle. Responses arrive back-to-back 4 cycles later in the same order, each matching ref_f. inflight saturates at 4.
- Fairness: requesters 1 and 3 held valid, ptr=2 → grant 3, then 1, then 3, alternating. Requester 0 asserts valid mid-stream and is granted within 2 cycles.
- issue_en=0 for 3 cycles while requests are pending → req_ready=0 throughout. In-flight results still return. Grants resume in the cycle issue_en returns high, from the unchanged ptr.
- rst_n low for 1 cycle with 3 results in flight → no rsp_valid pulses afterwards for those results. inflight=0, ptr=0, pipe_a..d=0. The first post-reset request is granted to the lowest valid index.
